// File: rtl/fetch.sv
// fetch: WISC instruction fetch stage. Holds the PC, reads instruction memory
// over a req/rdy handshake and feeds decode through a registered IF/ID output
// backed by a one-entry skid buffer.
module fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP_WORD = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_rdy,
  input  logic [15:0] imem_data,
  output logic [15:0] instruction,
  output logic [15:0] pc_plus2,
  output logic        instr_valid,
  output logic        halted,
  output logic        err
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_WAIT   = 2'd1,
    S_DROP   = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] drop_addr_q, drop_addr_d;
  logic [15:0] out_instr_q, out_instr_d;
  logic [15:0] out_pc2_q, out_pc2_d;
  logic        out_valid_q, out_valid_d;
  logic [15:0] skid_instr_q, skid_instr_d;
  logic [15:0] skid_pc2_q, skid_pc2_d;
  logic        skid_valid_q, skid_valid_d;
  logic        err_q, err_d;

  logic        req_raw;
  logic        accept;
  logic        is_halt;
  logic        out_hold;
  logic [15:0] pc_inc;

  // Request generation: FETCH issues only when the skid has room; WAIT and
  // DROP keep the outstanding request up until it completes.
  always_comb begin
    req_raw = 1'b0;
    case (state_q)
      S_FETCH:        req_raw = !skid_valid_q;
      S_WAIT, S_DROP: req_raw = 1'b1;
      default:        req_raw = 1'b0;
    endcase
  end

  // Request is masked while reset is held so nothing is issued during reset;
  // DROP keeps presenting the superseded address until its data arrives.
  assign imem_req  = req_raw & rst;
  assign imem_addr = (state_q == S_DROP) ? drop_addr_q : pc_q;

  assign is_halt  = (imem_data[15:11] == 5'b00000);
  assign accept   = imem_req && imem_rdy && !redirect &&
                    ((state_q == S_FETCH) || (state_q == S_WAIT));
  assign out_hold = out_valid_q && stall;
  assign pc_inc   = pc_q + 16'd2;

  // FSM next state and PC: redirect overrides everything, a redirect that
  // catches a request still in flight parks in DROP to swallow its data.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_addr_d = drop_addr_q;
    case (state_q)
      S_FETCH, S_WAIT: begin
        if (imem_req && !imem_rdy) begin
          if (redirect) begin
            state_d     = S_DROP;
            drop_addr_d = imem_addr;
          end else begin
            state_d = S_WAIT;
          end
        end else if (accept && is_halt) begin
          state_d = S_HALTED;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DROP: begin
        if (imem_rdy) state_d = S_FETCH;
      end
      S_HALTED: begin
        if (redirect) state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    if (redirect) begin
      pc_d = redirect_pc;
    end else if (accept && !is_halt) begin
      pc_d = pc_inc;
    end
  end

  // IF/ID register and skid: clear on redirect, hold on stall (parking any
  // new word in the skid), otherwise drain skid first, then the new word.
  always_comb begin
    out_instr_d  = out_instr_q;
    out_pc2_d    = out_pc2_q;
    out_valid_d  = out_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc2_d   = skid_pc2_q;
    skid_valid_d = skid_valid_q;
    if (redirect) begin
      out_valid_d  = 1'b0;
      out_instr_d  = NOP_WORD;
      skid_valid_d = 1'b0;
    end else if (out_hold) begin
      if (accept) begin
        skid_valid_d = 1'b1;
        skid_instr_d = imem_data;
        skid_pc2_d   = pc_inc;
      end
    end else if (skid_valid_q) begin
      out_valid_d  = 1'b1;
      out_instr_d  = skid_instr_q;
      out_pc2_d    = skid_pc2_q;
      skid_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      out_instr_d = imem_data;
      out_pc2_d   = pc_inc;
    end else begin
      out_valid_d = 1'b0;
      out_instr_d = NOP_WORD;
    end
  end

  // Sticky protocol error: data strobe with no request outstanding.
  always_comb begin
    err_d = err_q | (imem_rdy & ~imem_req);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      drop_addr_q  <= RESET_PC;
      out_instr_q  <= NOP_WORD;
      out_pc2_q    <= '0;
      out_valid_q  <= 1'b0;
      skid_instr_q <= NOP_WORD;
      skid_pc2_q   <= '0;
      skid_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drop_addr_q  <= drop_addr_d;
      out_instr_q  <= out_instr_d;
      out_pc2_q    <= out_pc2_d;
      out_valid_q  <= out_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc2_q   <= skid_pc2_d;
      skid_valid_q <= skid_valid_d;
      err_q        <= err_d;
    end
  end

  assign instruction = out_instr_q;
  assign pc_plus2    = out_pc2_q;
  assign instr_valid = out_valid_q;
  assign halted      = (state_q == S_HALTED);
  assign err         = err_q;

endmodule

// File: tb/tb_fetch.sv
// tb_fetch: scenario tasks for the fetch stage plus a randomized run checked
// against a queue-based model of words in flight to decode.
module tb_fetch;

  logic        clk = 1'b0;
  logic        rst, stall, redirect, imem_rdy;
  logic [15:0] redirect_pc, imem_data;
  logic        imem_req, instr_valid, halted, err;
  logic [15:0] imem_addr, instruction, pc_plus2;

  localparam logic [15:0] NOP = 16'h0800;
  localparam int unsigned CTL_AUTO  = 0;
  localparam int unsigned CTL_LOW   = 1;
  localparam int unsigned CTL_HIGH  = 2;
  localparam int unsigned CTL_FORCE = 3;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned wait_n = 0;
  int unsigned wcnt = 0;
  bit          rand_wait = 1'b0;
  bit          halt_en = 1'b0;
  logic [15:0] halt_addr = '0;
  logic        last_req, last_rdy;
  logic [15:0] last_addr;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc2;
  } item_t;

  fetch #(.RESET_PC(16'h0000), .NOP_WORD(16'h0800)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdy(imem_rdy), .imem_data(imem_data), .instruction(instruction),
    .pc_plus2(pc_plus2), .instr_valid(instr_valid), .halted(halted), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (halt_en && a == halt_addr) return 16'h0000;
    return a + 16'h1000;
  endfunction

  // One clock: drive controls, answer memory, advance to 1 time unit past the edge.
  task automatic tick(input logic r, input logic s, input logic rd,
                      input logic [15:0] rpc, input int unsigned ctl);
    logic go;
    rst = r; stall = s; redirect = rd; redirect_pc = rpc;
    #1;
    last_req  = imem_req;
    last_addr = imem_addr;
    case (ctl)
      CTL_LOW:   go = 1'b0;
      CTL_HIGH:  go = imem_req;
      CTL_FORCE: go = 1'b1;
      default:   go = imem_req && (rand_wait ? ($urandom_range(0, 2) == 0) : (wcnt >= wait_n));
    endcase
    if (go) wcnt = 0;
    else if (imem_req) wcnt++;
    imem_rdy  = go;
    imem_data = go ? mem_word(imem_addr) : 16'($urandom);
    last_rdy  = go;
    @(posedge clk);
    #1;
    imem_rdy = 1'b0;
    redirect = 1'b0;
  endtask

  task automatic do_reset();
    wcnt = 0; wait_n = 0; rand_wait = 1'b0; halt_en = 1'b0;
    tick(1'b0, 1'b0, 1'b0, '0, CTL_AUTO);
    tick(1'b0, 1'b0, 1'b0, '0, CTL_AUTO);
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
    n_cmp++; if (instruction !== NOP) begin n_bad++; $display("FAIL reset_instr: got %h want %h", instruction, NOP); end
    n_cmp++; if (pc_plus2 !== 16'h0000) begin n_bad++; $display("FAIL reset_pc2: got %h want 0000", pc_plus2); end
    n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL reset_halted: got %b want 0", halted); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b want 0", imem_req); end
    tick(1'b1, 1'b0, 1'b0, '0, CTL_LOW);
    n_cmp++; if (last_req !== 1'b1 || last_addr !== 16'h0000) begin
      n_bad++; $display("FAIL reset_first_req: got req=%b addr=%h want req=1 addr=0000", last_req, last_addr);
    end
  endtask

  task automatic test_zero_wait();
    logic [15:0] exp;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      exp = 16'(2 * k);
      tick(1'b1, 1'b0, 1'b0, '0, CTL_AUTO);
      n_cmp++; if (last_req !== 1'b1 || last_addr !== exp) begin
        n_bad++; $display("FAIL zw_addr[%0d]: got req=%b addr=%h want req=1 addr=%h", k, last_req, last_addr, exp);
      end
      n_cmp++; if (instr_valid !== 1'b1 || instruction !== exp + 16'h1000) begin
        n_bad++; $display("FAIL zw_instr[%0d]: got v=%b %h want v=1 %h", k, instr_valid, instruction, exp + 16'h1000);
      end
      n_cmp++; if (pc_plus2 !== exp + 16'd2) begin
        n_bad++; $display("FAIL zw_pc2[%0d]: got %h want %h", k, pc_plus2, exp + 16'd2);
      end
    end
  endtask

  task automatic test_wait_states();
    logic [15:0] exp;
    do_reset();
    wait_n = 3;
    exp = 16'h0000;
    for (int k = 0; k < 16; k++) begin
      tick(1'b1, 1'b0, 1'b0, '0, CTL_AUTO);
      n_cmp++; if (last_req !== 1'b1 || last_addr !== exp) begin
        n_bad++; $display("FAIL ws_addr[%0d]: got req=%b addr=%h want req=1 addr=%h", k, last_req, last_addr, exp);
      end
      n_cmp++; if (instr_valid !== last_rdy) begin
        n_bad++; $display("FAIL ws_valid[%0d]: got %b want %b", k, instr_valid, last_rdy);
      end
      if (last_rdy) begin
        n_cmp++; if (instruction !== exp + 16'h1000) begin
          n_bad++; $display("FAIL ws_instr[%0d]: got %h want %h", k, instruction, exp + 16'h1000);
        end
        exp = exp + 16'd2;
      end else begin
        n_cmp++; if (instruction !== NOP) begin
          n_bad++; $display("FAIL ws_nop[%0d]: got %h want %h", k, instruction, NOP);
        end
      end
    end
  endtask

  task automatic test_stall_skid();
    do_reset();
    tick(1'b1, 1'b0, 1'b0, '0, CTL_AUTO);
    n_cmp++; if (instruction !== 16'h1000 || instr_valid !== 1'b1) begin
      n_bad++; $display("FAIL sk_first: got v=%b %h want v=1 1000", instr_valid, instruction);
    end
    tick(1'b1, 1'b1, 1'b0, '0, CTL_AUTO);
    n_cmp++; if (last_req !== 1'b1 || last_addr !== 16'h0002) begin
      n_bad++; $display("FAIL sk_fill_req: got req=%b addr=%h want req=1 addr=0002", last_req, last_addr);
    end
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (instruction !== 16'h1000 || instr_valid !== 1'b1) begin
        n_bad++; $display("FAIL sk_hold[%0d]: got v=%b %h want v=1 1000", k, instr_valid, instruction);
      end
      if (k < 2) begin
        tick(1'b1, 1'b1, 1'b0, '0, CTL_AUTO);
        n_cmp++; if (last_req !== 1'b0) begin
          n_bad++; $display("FAIL sk_noreq[%0d]: got %b want 0", k, last_req);
        end
      end
    end
    tick(1'b1, 1'b0, 1'b0, '0, CTL_AUTO);
    n_cmp++; if (last_req !== 1'b0) begin n_bad++; $display("FAIL sk_rel_req: got %b want 0", last_req); end
    n_cmp++; if (instruction !== 16'h1002 || pc_plus2 !== 16'h0004 || instr_valid !== 1'b1) begin
      n_bad++; $display("FAIL sk_drain: got v=%b %h/%h want v=1 1002/0004", instr_valid, instruction, pc_plus2);
    end
    for (int k = 0; k < 2; k++) begin
      tick(1'b1, 1'b0, 1'b0, '0, CTL_AUTO);
      n_cmp++; if (last_addr !== 16'(4 + 2 * k) || instruction !== 16'(16'h1004 + 2 * k)) begin
        n_bad++; $display("FAIL sk_resume[%0d]: got addr=%h instr=%h want addr=%h instr=%h",
                          k, last_addr, instruction, 16'(4 + 2 * k), 16'(16'h1004 + 2 * k));
      end
    end
  endtask

  task automatic test_redirect_drop();
    do_reset();
    for (int k = 0; k < 8; k++) tick(1'b1, 1'b0, 1'b0, '0, CTL_AUTO);
    tick(1'b1, 1'b0, 1'b0, '0, CTL_LOW);
    n_cmp++; if (last_req !== 1'b1 || last_addr !== 16'h0010) begin
      n_bad++; $display("FAIL rd_wait_req: got req=%b addr=%h want req=1 addr=0010", last_req, last_addr);
    end
    tick(1'b1, 1'b0, 1'b1, 16'h0040, CTL_LOW);
    n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL rd_clear: got %b want 0", instr_valid); end
    tick(1'b1, 1'b0, 1'b0, '0, CTL_LOW);
    n_cmp++; if (last_req !== 1'b1 || last_addr !== 16'h0010) begin
      n_bad++; $display("FAIL rd_drop_hold: got req=%b addr=%h want req=1 addr=0010", last_req, last_addr);
    end
    tick(1'b1, 1'b0, 1'b0, '0, CTL_HIGH);
    n_cmp++; if (instr_valid !== 1'b0) begin
      n_bad++; $display("FAIL rd_discard: got v=%b instr=%h want v=0", instr_valid, instruction);
    end
    tick(1'b1, 1'b0, 1'b0, '0, CTL_AUTO);
    n_cmp++; if (last_req !== 1'b1 || last_addr !== 16'h0040) begin
      n_bad++; $display("FAIL rd_new_req: got req=%b addr=%h want req=1 addr=0040", last_req, last_addr);
    end
    n_cmp++; if (instr_valid !== 1'b1 || instruction !== 16'h1040 || pc_plus2 !== 16'h0042) begin
      n_bad++; $display("FAIL rd_new_instr: got v=%b %h/%h want v=1 1040/0042", instr_valid, instruction, pc_plus2);
    end
  endtask

  task automatic test_halt();
    do_reset();
    halt_en = 1'b1; halt_addr = 16'h0006;
    for (int k = 0; k < 4; k++) tick(1'b1, 1'b0, 1'b0, '0, CTL_AUTO);
    n_cmp++; if (instr_valid !== 1'b1 || instruction !== 16'h0000 || pc_plus2 !== 16'h0008) begin
      n_bad++; $display("FAIL ht_word: got v=%b %h/%h want v=1 0000/0008", instr_valid, instruction, pc_plus2);
    end
    n_cmp++; if (halted !== 1'b1) begin n_bad++; $display("FAIL ht_flag: got %b want 1", halted); end
    for (int k = 0; k < 3; k++) begin
      tick(1'b1, 1'b0, 1'b0, '0, CTL_AUTO);
      n_cmp++; if (last_req !== 1'b0 || halted !== 1'b1 || instr_valid !== 1'b0) begin
        n_bad++; $display("FAIL ht_idle[%0d]: got req=%b halted=%b v=%b want 0/1/0", k, last_req, halted, instr_valid);
      end
    end
    tick(1'b1, 1'b0, 1'b1, 16'h0020, CTL_AUTO);
    n_cmp++; if (halted !== 1'b0 || instr_valid !== 1'b0) begin
      n_bad++; $display("FAIL ht_release: got halted=%b v=%b want 0/0", halted, instr_valid);
    end
    tick(1'b1, 1'b0, 1'b0, '0, CTL_AUTO);
    n_cmp++; if (last_req !== 1'b1 || last_addr !== 16'h0020) begin
      n_bad++; $display("FAIL ht_resume_req: got req=%b addr=%h want req=1 addr=0020", last_req, last_addr);
    end
    n_cmp++; if (instruction !== 16'h1020 || pc_plus2 !== 16'h0022) begin
      n_bad++; $display("FAIL ht_resume_instr: got %h/%h want 1020/0022", instruction, pc_plus2);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    tick(1'b1, 1'b0, 1'b0, '0, CTL_AUTO);
    tick(1'b1, 1'b0, 1'b1, 16'hFFFE, CTL_AUTO);
    n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL wr_clear: got %b want 0", instr_valid); end
    tick(1'b1, 1'b0, 1'b0, '0, CTL_AUTO);
    n_cmp++; if (last_addr !== 16'hFFFE || instruction !== 16'h0FFE || pc_plus2 !== 16'h0000) begin
      n_bad++; $display("FAIL wr_top: got addr=%h %h/%h want FFFE 0FFE/0000", last_addr, instruction, pc_plus2);
    end
    tick(1'b1, 1'b0, 1'b0, '0, CTL_AUTO);
    n_cmp++; if (last_addr !== 16'h0000 || instruction !== 16'h1000 || pc_plus2 !== 16'h0002 || err !== 1'b0) begin
      n_bad++; $display("FAIL wr_wrapped: got addr=%h %h/%h err=%b want 0000 1000/0002 err=0",
                        last_addr, instruction, pc_plus2, err);
    end
  endtask

  task automatic test_err();
    do_reset();
    tick(1'b1, 1'b0, 1'b0, '0, CTL_AUTO);
    tick(1'b1, 1'b1, 1'b0, '0, CTL_AUTO);
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL er_before: got %b want 0", err); end
    tick(1'b1, 1'b1, 1'b0, '0, CTL_FORCE);
    n_cmp++; if (last_req !== 1'b0) begin n_bad++; $display("FAIL er_idle: got req=%b want 0", last_req); end
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL er_set: got %b want 1", err); end
    for (int k = 0; k < 3; k++) begin
      tick(1'b1, 1'b0, 1'b0, '0, CTL_AUTO);
      n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL er_sticky[%0d]: got %b want 1", k, err); end
    end
    tick(1'b0, 1'b0, 1'b0, '0, CTL_AUTO);
    n_cmp++; if (err !== 1'b0 || instr_valid !== 1'b0 || instruction !== NOP || halted !== 1'b0) begin
      n_bad++; $display("FAIL er_reset: got err=%b v=%b instr=%h halted=%b want 0/0/%h/0",
                        err, instr_valid, instruction, halted, NOP);
    end
  endtask

  task automatic test_random();
    item_t       q[$];
    item_t       it;
    logic [15:0] exp_pc;
    logic        s, exp_v, exp_req;
    int unsigned pend;
    do_reset();
    rand_wait = 1'b1;
    exp_pc = 16'h0000;
    for (int k = 0; k < 400; k++) begin
      exp_v = (q.size() != 0);
      n_cmp++; if (instr_valid !== exp_v) begin
        n_bad++; $display("FAIL rnd_valid[%0d]: got %b want %b", k, instr_valid, exp_v);
      end
      if (exp_v) begin
        n_cmp++; if (instruction !== q[0].instr || pc_plus2 !== q[0].pc2) begin
          n_bad++; $display("FAIL rnd_word[%0d]: got %h/%h want %h/%h", k, instruction, pc_plus2, q[0].instr, q[0].pc2);
        end
      end else begin
        n_cmp++; if (instruction !== NOP) begin
          n_bad++; $display("FAIL rnd_nop[%0d]: got %h want %h", k, instruction, NOP);
        end
      end
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rnd_err[%0d]: got %b want 0", k, err); end
      pend = q.size();
      s = ($urandom_range(0, 2) == 0);
      tick(1'b1, s, 1'b0, '0, CTL_AUTO);
      exp_req = (pend < 2);
      n_cmp++; if (last_req !== exp_req) begin
        n_bad++; $display("FAIL rnd_req[%0d]: got %b want %b", k, last_req, exp_req);
      end
      if (last_req === 1'b1) begin
        n_cmp++; if (last_addr !== exp_pc) begin
          n_bad++; $display("FAIL rnd_addr[%0d]: got %h want %h", k, last_addr, exp_pc);
        end
      end
      if (pend != 0 && !s) void'(q.pop_front());
      if (last_req === 1'b1 && last_rdy) begin
        it.instr = mem_word(exp_pc);
        it.pc2   = exp_pc + 16'd2;
        q.push_back(it);
        exp_pc = exp_pc + 16'd2;
      end
    end
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_rdy = 1'b0; imem_data = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_stall_skid();
    test_redirect_drop();
    test_halt();
    test_wrap();
    test_err();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
